// File: rtl/gpr_scoreboard_pkg.sv
// Shared definitions for the GPR scoreboard: register addressing, GPR count,
// default widths and a small helper for "real" (non-$0) registers.
package gpr_scoreboard_pkg;
  localparam int REG_ADDR_W  = 5;
  localparam int NUM_GPR     = 32;
  localparam int CNT_W_DEF   = 2;
  localparam int OUT_W_DEF   = 3;
  localparam int MAX_OUT_DEF = 4;
  localparam int CP0_HAZ_DEF = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // $0 is hardwired to zero, so it never carries a pending write
  function automatic logic is_gpr(reg_addr_t a);
    return a != '0;
  endfunction
endpackage

// File: rtl/gpr_scoreboard_if.sv
// ID-decode <-> scoreboard bundle: decoded operand info, WB completion and
// the scoreboard's stall/issue/status outputs.
interface gpr_scoreboard_if
  import gpr_scoreboard_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
);
  logic             id_valid;
  logic             flush;
  logic             reg_read_en_1;
  reg_addr_t        reg_addr_1;
  logic             reg_read_en_2;
  reg_addr_t        reg_addr_2;
  logic             reg_write_en;
  reg_addr_t        reg_write_addr;
  logic             long_op;
  logic             cp_read_en;
  logic             cp_write_en;
  logic             wb_done;
  reg_addr_t        wb_addr;
  logic             stall_id;
  logic             issue;
  logic [OUT_W-1:0] outstanding;
  logic             cp0_busy;

  modport master (
    output id_valid, flush, reg_read_en_1, reg_addr_1, reg_read_en_2, reg_addr_2,
           reg_write_en, reg_write_addr, long_op, cp_read_en, cp_write_en,
           wb_done, wb_addr,
    input  stall_id, issue, outstanding, cp0_busy
  );

  modport slave (
    input  id_valid, flush, reg_read_en_1, reg_addr_1, reg_read_en_2, reg_addr_2,
           reg_write_en, reg_write_addr, long_op, cp_read_en, cp_write_en,
           wb_done, wb_addr,
    output stall_id, issue, outstanding, cp0_busy
  );
endinterface

// File: rtl/gpr_scoreboard_sb_counter.sv
// One per-register pending-write counter. Saturates at both ends; inc and
// dec in the same cycle cancel.
module sb_counter
  import gpr_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign full = &cnt_q;

  // next count: step only when exactly one of inc/dec is active and in range
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !full)      cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc && !zero) cnt_d = cnt_q - CNT_W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/gpr_scoreboard.sv
// ID-stage hazard controller: tracks in-flight long-latency GPR writes and
// the MTC0->MFC0 window, and stalls ID until its operands are safe.
// Optional macro SB_WB_BYPASS_EN: a read whose last pending write completes
// this cycle is not stalled (register file writes through).
module gpr_scoreboard
  import gpr_scoreboard_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int CP0_HAZ = CP0_HAZ_DEF
) (
  input  logic          clk,
  input  logic          rst,
  gpr_scoreboard_if.slave sb
);
  localparam int CP0_W = (CP0_HAZ < 2) ? 1 : $clog2(CP0_HAZ + 1);

  logic [NUM_GPR-1:0][CNT_W-1:0] pend;
  logic [NUM_GPR-1:0]            pz, pf;

  logic [OUT_W-1:0] out_q, out_d;
  logic [CP0_W-1:0] cp0_q, cp0_d;
  logic             cp0_busy_q, cp0_busy_d;

  logic byp1, byp2, hit1, hit2, struct_haz, waw_sat, cp0_hit;
  logic stall, iss, lg_iss, comp_ok;

  // $0 has no counter
  assign pend[0] = '0;
  assign pz[0]   = 1'b1;
  assign pf[0]   = 1'b0;

  // per-register pending counters for $1..$31
  for (genvar g = 1; g < NUM_GPR; g++) begin : g_pend
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (lg_iss  && is_gpr(sb.reg_write_addr) && (sb.reg_write_addr == reg_addr_t'(g))),
      .dec  (comp_ok && (sb.wb_addr == reg_addr_t'(g))),
      .cnt  (pend[g]),
      .zero (pz[g]),
      .full (pf[g])
    );
  end

  // hazard detection, stall and issue; all forced low while in reset
  always_comb begin
`ifdef SB_WB_BYPASS_EN
    byp1 = sb.wb_done && (sb.wb_addr == sb.reg_addr_1) && (pend[sb.reg_addr_1] == CNT_W'(1));
    byp2 = sb.wb_done && (sb.wb_addr == sb.reg_addr_2) && (pend[sb.reg_addr_2] == CNT_W'(1));
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    hit1       = sb.reg_read_en_1 && is_gpr(sb.reg_addr_1) && !pz[sb.reg_addr_1] && !byp1;
    hit2       = sb.reg_read_en_2 && is_gpr(sb.reg_addr_2) && !pz[sb.reg_addr_2] && !byp2;
    struct_haz = sb.long_op && sb.reg_write_en && (out_q == OUT_W'(MAX_OUT));
    waw_sat    = sb.long_op && sb.reg_write_en && pf[sb.reg_write_addr];
    cp0_hit    = sb.cp_read_en && (cp0_q != '0);
    stall      = rst && sb.id_valid && (hit1 || hit2 || struct_haz || waw_sat || cp0_hit);
    iss        = rst && sb.id_valid && !stall && !sb.flush;
    // long ops to $0 still occupy a slot and still get a wb_done
    lg_iss     = iss && sb.long_op && sb.reg_write_en;
    // a completion with nothing pending is dropped so nothing underflows
    comp_ok    = sb.wb_done && (out_q != '0) && (!is_gpr(sb.wb_addr) || !pz[sb.wb_addr]);
  end

  // outstanding count and CP0 hazard window next state
  always_comb begin
    out_d = out_q;
    if (lg_iss && !comp_ok)      out_d = out_q + OUT_W'(1);
    else if (!lg_iss && comp_ok) out_d = out_q - OUT_W'(1);
    cp0_d = cp0_q;
    if (iss && sb.cp_write_en) cp0_d = CP0_W'(CP0_HAZ);
    else if (cp0_q != '0)      cp0_d = cp0_q - CP0_W'(1);
    cp0_busy_d = (cp0_d != '0);
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      cp0_q      <= '0;
      cp0_busy_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      cp0_q      <= cp0_d;
      cp0_busy_q <= cp0_busy_d;
    end
  end

  assign sb.stall_id    = stall;
  assign sb.issue       = iss;
  assign sb.outstanding = out_q;
  assign sb.cp0_busy    = cp0_busy_q;

  // completion must always match an in-flight write
  a_wb_match: assert property (@(posedge clk) disable iff (!rst)
    sb.wb_done |-> ((out_q != '0) && (!is_gpr(sb.wb_addr) || !pz[sb.wb_addr])));
endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: RAW stall/release, structural limit,
// $0 handling, same-cycle issue+completion, WAW saturation, CP0 window,
// asynchronous reset mid-stall.
module tb_gpr_scoreboard;
  import gpr_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  gpr_scoreboard_if #(.OUT_W(3)) sbif ();

  gpr_scoreboard #(.MAX_OUT(4), .CNT_W(2), .OUT_W(3), .CP0_HAZ(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbif.id_valid       = 1'b0;
    sbif.flush          = 1'b0;
    sbif.reg_read_en_1  = 1'b0;
    sbif.reg_addr_1     = '0;
    sbif.reg_read_en_2  = 1'b0;
    sbif.reg_addr_2     = '0;
    sbif.reg_write_en   = 1'b0;
    sbif.reg_write_addr = '0;
    sbif.long_op        = 1'b0;
    sbif.cp_read_en     = 1'b0;
    sbif.cp_write_en    = 1'b0;
    sbif.wb_done        = 1'b0;
    sbif.wb_addr        = '0;
  endtask

  // long-latency load into rd
  task automatic lw(input int rd);
    idle();
    sbif.id_valid       = 1'b1;
    sbif.reg_write_en   = 1'b1;
    sbif.reg_write_addr = reg_addr_t'(rd);
    sbif.long_op        = 1'b1;
  endtask

  // single-cycle op reading ra and rb
  task automatic alu(input int ra, input int rb);
    idle();
    sbif.id_valid      = 1'b1;
    sbif.reg_read_en_1 = 1'b1;
    sbif.reg_addr_1    = reg_addr_t'(ra);
    sbif.reg_read_en_2 = 1'b1;
    sbif.reg_addr_2    = reg_addr_t'(rb);
    sbif.reg_write_en  = 1'b1;
    sbif.reg_write_addr = reg_addr_t'(3);
  endtask

  task automatic wb(input int rd);
    sbif.wb_done = 1'b1;
    sbif.wb_addr = reg_addr_t'(rd);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // reset: valid instruction present, nothing may issue
    sbif.id_valid = 1'b1;
    #12;
    chk("rst_stall", sbif.stall_id, 0);
    chk("rst_issue", sbif.issue, 0);
    chk("rst_out",   sbif.outstanding, 0);
    chk("rst_cp0",   sbif.cp0_busy, 0);
    idle();
    #10 rst = 1'b1;
    tick();

    // flushed LW does not issue or count
    lw(8); sbif.flush = 1'b1; #2;
    chk("flush_issue", sbif.issue, 0);
    tick(); idle(); #2;
    chk("flush_out", sbif.outstanding, 0);

    // RAW on a load result
    lw(5); #2;
    chk("lw5_issue", sbif.issue, 1);
    tick();
    alu(5, 6); #2;
    chk("raw_out", sbif.outstanding, 1);
    chk("raw_stall", sbif.stall_id, 1);
    chk("raw_issue", sbif.issue, 0);
    tick();
    sbif.flush = 1'b1; #2;
    chk("raw_flush_stall", sbif.stall_id, 1);
    sbif.flush = 1'b0;
    tick();
    wb(5); #2;
`ifdef SB_WB_BYPASS_EN
    chk("raw_byp_issue", sbif.issue, 1);
    tick(); idle(); #2;
`else
    chk("raw_wb_stall", sbif.stall_id, 1);
    tick();
    sbif.wb_done = 1'b0; #2;
    chk("raw_rel_issue", sbif.issue, 1);
    tick(); idle(); #2;
`endif
    chk("raw_drain_out", sbif.outstanding, 0);

    // structural limit: four in flight, fifth waits for a slot
    for (int r = 1; r <= 4; r++) begin
      lw(r); #2;
      chk("fill_issue", sbif.issue, 1);
      tick();
    end
    lw(6); #2;
    chk("full_out", sbif.outstanding, 4);
    chk("full_stall", sbif.stall_id, 1);
    tick();
    wb(1); #2;
    chk("full_wb_stall", sbif.stall_id, 1);
    tick();
    sbif.wb_done = 1'b0; #2;
    chk("slot_out", sbif.outstanding, 3);
    chk("slot_issue", sbif.issue, 1);
    tick(); idle(); #2;
    chk("slot_out4", sbif.outstanding, 4);
    wb(2); tick(); wb(3); tick(); wb(4); tick(); wb(6); tick(); idle(); #2;
    chk("fill_drain_out", sbif.outstanding, 0);

    // $0 destination: counts in flight, never blocks readers
    lw(0); #2;
    chk("lw0_issue", sbif.issue, 1);
    tick();
    alu(0, 0); #2;
    chk("lw0_out", sbif.outstanding, 1);
    chk("rd0_stall", sbif.stall_id, 0);
    tick();
    idle(); wb(0); tick(); idle(); #2;
    chk("lw0_drain_out", sbif.outstanding, 0);

    // same-register issue and completion in one cycle
    lw(7); tick();
    lw(7); wb(7); #2;
    chk("same_issue", sbif.issue, 1);
    tick(); idle(); #2;
    chk("same_out", sbif.outstanding, 1);
    alu(7, 7); #2;
    chk("same_pend1_stall", sbif.stall_id, 1);
    tick();
    idle(); wb(7); tick(); idle(); #2;
    chk("same_drain_out", sbif.outstanding, 0);
    alu(7, 7); #2;
    chk("same_pend0_stall", sbif.stall_id, 0);
    tick();

    // WAW saturation: third pending write to $10 fills the counter
    for (int i = 0; i < 3; i++) begin lw(10); tick(); end
    lw(10); #2;
    chk("waw_out", sbif.outstanding, 3);
    chk("waw_stall", sbif.stall_id, 1);
    tick();
    idle(); wb(10); tick(); wb(10); tick(); wb(10); tick(); idle(); #2;
    chk("waw_drain_out", sbif.outstanding, 0);

    // CP0 window: MTC0 then MFC0
    idle(); sbif.id_valid = 1'b1; sbif.cp_write_en = 1'b1; #2;
    chk("mtc0_issue", sbif.issue, 1);
    tick();
    idle(); sbif.id_valid = 1'b1; sbif.cp_read_en = 1'b1; #2;
    chk("cp0_busy1", sbif.cp0_busy, 1);
    chk("mfc0_stall1", sbif.stall_id, 1);
    tick(); #1;
    chk("cp0_busy2", sbif.cp0_busy, 1);
    chk("mfc0_stall2", sbif.stall_id, 1);
    tick(); #1;
    chk("cp0_busy3", sbif.cp0_busy, 0);
    chk("mfc0_issue", sbif.issue, 1);
    tick();

    // asynchronous reset while stalled on $9 (pend=2)
    lw(9); tick(); lw(9); tick();
    alu(9, 1); #2;
    chk("p9_out", sbif.outstanding, 2);
    chk("p9_stall", sbif.stall_id, 1);
    rst = 1'b0; #1;
    chk("arst_stall", sbif.stall_id, 0);
    chk("arst_out", sbif.outstanding, 0);
    #3 rst = 1'b1;
    tick(); #1;
    chk("arst_rd9_stall", sbif.stall_id, 0);
    chk("arst_rd9_issue", sbif.issue, 1);
    tick(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
